// File: rtl/log2_pkg.sv
// log2_pkg: shared widths and lookup tables for the log2 / antilog2 blocks
// exp2_mfrac : f (x/16) -> round((2^(f/16)-1)*32), the 1.5 mantissa fraction
// exp2_lin   : {e, mfrac} -> (32+mfrac) << (e+3), 16.8 linear result
package log2_pkg;
    localparam int LOG_W       = 8;
    localparam int LIN_W       = 24;
    localparam int MANT_FRAC_W = 5;

    function automatic logic [MANT_FRAC_W-1:0] exp2_mfrac(input logic [3:0] f);
        logic [MANT_FRAC_W-1:0] m;
        case (f)
            4'd0:    m = 5'd0;
            4'd1:    m = 5'd1;
            4'd2:    m = 5'd3;
            4'd3:    m = 5'd4;
            4'd4:    m = 5'd6;
            4'd5:    m = 5'd8;
            4'd6:    m = 5'd9;
            4'd7:    m = 5'd11;
            4'd8:    m = 5'd13;
            4'd9:    m = 5'd15;
            4'd10:   m = 5'd17;
            4'd11:   m = 5'd20;
            4'd12:   m = 5'd22;
            4'd13:   m = 5'd24;
            4'd14:   m = 5'd27;
            default: m = 5'd29;
        endcase
        return m;
    endfunction

    // Shift amount needs 5 bits: e+3 reaches 18. Largest result 61<<18 fits 24 bits.
    function automatic logic [LIN_W-1:0] exp2_lin(input logic [3:0] e,
                                                  input logic [MANT_FRAC_W-1:0] m);
        return LIN_W'({1'b1, m}) << ({1'b0, e} + 5'd3);
    endfunction
endpackage

// File: rtl/exp2_frac_lut.sv
// exp2_frac_lut: combinational fraction table, f_i (4b) -> mfrac_o (5b)
module exp2_frac_lut
    import log2_pkg::*;
(
    input  logic [3:0]             f_i,
    output logic [MANT_FRAC_W-1:0] mfrac_o
);
    always_comb mfrac_o = exp2_mfrac(f_i);
endmodule

// File: rtl/antilog2_pipe.sv
// antilog2_pipe: streaming exp2, 4.4 log in -> 16.8 linear out, valid/ready
// Ports: CLK, RSTN (async low); DIN_VALID/DIN_READY/DIN[7:0] input stream;
//        DOUT_VALID/DOUT_READY/DOUT[23:0] output stream.
// REG_LUT=1 registers {e, mfrac} before the shift (latency 2), 0 gives latency 1.
module antilog2_pipe
    import log2_pkg::*;
#(
    parameter bit REG_LUT = 1'b1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    input  logic [LOG_W-1:0] DIN,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic [LIN_W-1:0] DOUT
);
    logic [MANT_FRAC_W-1:0] din_mfrac;
    logic                   dout_valid_q, dout_valid_d;
    logic [LIN_W-1:0]       dout_q, dout_d;

    exp2_frac_lut u_lut (.f_i(DIN[3:0]), .mfrac_o(din_mfrac));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
        end
    end

    assign DOUT_VALID = dout_valid_q;
    assign DOUT       = dout_q;

    if (REG_LUT) begin : g_reg
        logic                   s1_valid_q, s1_valid_d;
        logic [3:0]             s1_e_q, s1_e_d;
        logic [MANT_FRAC_W-1:0] s1_m_q, s1_m_d;
        logic                   s1_load, s2_load;

        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                s1_valid_q <= 1'b0;
                s1_e_q     <= '0;
                s1_m_q     <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_e_q     <= s1_e_d;
                s1_m_q     <= s1_m_d;
            end
        end

        // Ready depends only on pipeline state and DOUT_READY, never on DIN_VALID.
        always_comb begin
            s2_load      = s1_valid_q && (!dout_valid_q || DOUT_READY);
            DIN_READY    = !s1_valid_q || s2_load;
            s1_load      = DIN_VALID && DIN_READY;
            s1_valid_d   = s1_load || (s1_valid_q && !s2_load);
            s1_e_d       = s1_load ? DIN[7:4] : s1_e_q;
            s1_m_d       = s1_load ? din_mfrac : s1_m_q;
            dout_valid_d = s2_load || (dout_valid_q && !DOUT_READY);
            dout_d       = s2_load ? exp2_lin(s1_e_q, s1_m_q) : dout_q;
        end
    end else begin : g_comb
        logic load;

        always_comb begin
            DIN_READY    = !dout_valid_q || DOUT_READY;
            load         = DIN_VALID && DIN_READY;
            dout_valid_d = load || (dout_valid_q && !DOUT_READY);
            dout_d       = load ? exp2_lin(DIN[7:4], din_mfrac) : dout_q;
        end
    end
endmodule

// File: tb/tb_antilog2_pipe.sv
// tb_antilog2_pipe: self-checking bench for antilog2_pipe (REG_LUT=1)
module tb_antilog2_pipe;
    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        DIN_VALID = 1'b0;
    logic        DIN_READY;
    logic [7:0]  DIN = 8'h00;
    logic        DOUT_VALID;
    logic        DOUT_READY = 1'b0;
    logic [23:0] DOUT;

    antilog2_pipe #(.REG_LUT(1'b1)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .DIN(DIN),
        .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .DOUT(DOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {logic [7:0] din; logic [23:0] exp;} vec_t;

    int          checks = 0;
    int          failures = 0;
    int          out_cnt = 0;
    bit          stall = 1'b0;
    bit          rt_en = 1'b0;
    logic [23:0] hold = '0;
    logic [23:0] last_out = '0;
    vec_t        sb[$];
    logic [23:0] out_log[$];
    vec_t        vecs[6];

    // Reference: 2^(e+f/16)*256 with the mantissa rounded to 1/32.
    function automatic logic [23:0] model(input logic [7:0] x);
        int  e = int'(x[7:4]);
        int  f = int'(x[3:0]);
        int  mf = $rtoi((2.0 ** (real'(f) / 16.0) - 1.0) * 32.0 + 0.5);
        longint v = longint'(32 + mf) * (longint'(1) << (e + 3));
        return v[23:0];
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic roundtrip(input logic [7:0] x, input logic [23:0] o);
        real r = $ln(real'(o) / 256.0) / $ln(2.0) * 16.0;
        int  ri = $rtoi(r + 0.5);
        int  diff = ri - int'(x);
        chk((x[1:0] == 2'b00) ? (diff == 0) : (diff >= -1 && diff <= 1), "roundtrip", 32'(ri), 32'(x));
    endtask

    // One clock of stimulus; handshakes are sampled mid low phase and complete on the next rising edge.
    task automatic cyc(input bit v, input logic [7:0] d, input bit r);
        vec_t e;
        @(negedge CLK);
        DIN_VALID = v;
        DIN = d;
        DOUT_READY = r;
        #1;
        if (stall) chk(DOUT_VALID && DOUT == hold, "hold", DOUT, hold);
        stall = DOUT_VALID && !DOUT_READY;
        hold = DOUT;
        if (DIN_VALID && DIN_READY) sb.push_back('{d, model(d)});
        if (DOUT_VALID && DOUT_READY) begin
            if (sb.size() == 0) chk(1'b0, "dup", DOUT, 0);
            else begin
                e = sb.pop_front();
                chk(DOUT == e.exp, "data", DOUT, e.exp);
                if (rt_en) roundtrip(e.din, DOUT);
            end
            last_out = DOUT;
            out_log.push_back(DOUT);
            out_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTN = 1'b0;
        DIN_VALID = 1'b0;
        DOUT_READY = 1'b0;
        sb.delete();
        stall = 1'b0;
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
    endtask

    initial begin
        int n0;
        int lat;
        int cycles;
        vecs[0] = '{8'h00, 24'h000100};
        vecs[1] = '{8'h10, 24'h000200};
        vecs[2] = '{8'h48, 24'h001680};
        vecs[3] = '{8'hFF, 24'hF40000};
        vecs[4] = '{8'hF0, 24'h800000};
        vecs[5] = '{8'h06, 24'h000148};

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        #1;
        chk(!DOUT_VALID, "rst_valid", 32'(DOUT_VALID), 0);
        chk(DOUT == 24'h0, "rst_dout", DOUT, 0);
        chk(DIN_READY, "rst_ready", 32'(DIN_READY), 1);

        foreach (vecs[i]) begin
            cyc(1'b1, vecs[i].din, 1'b1);
            chk(DIN_READY, "vec_accept", 32'(DIN_READY), 1);
            n0 = out_cnt;
            lat = 0;
            while (out_cnt == n0 && lat < 6) begin
                cyc(1'b0, 8'h00, 1'b1);
                lat++;
            end
            chk(last_out == vecs[i].exp, "vec_data", last_out, vecs[i].exp);
            chk(lat == 2, "vec_latency", 32'(lat), 2);
        end

        rt_en = 1'b1;
        n0 = out_cnt;
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 8'(i), 1'b1);
            chk(DIN_READY, "sweep_ready", 32'(DIN_READY), 1);
        end
        repeat (3) cyc(1'b0, 8'h00, 1'b1);
        chk(out_cnt - n0 == 256, "sweep_count", 32'(out_cnt - n0), 256);
        rt_en = 1'b0;

        do_reset();
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h10, 1'b0);
        cyc(1'b1, 8'h20, 1'b0);
        chk(!DIN_READY, "full_ready", 32'(DIN_READY), 0);
        chk(DOUT_VALID && DOUT == 24'h000100, "full_dout", DOUT, 24'h000100);
        repeat (3) begin
            cyc(1'b1, 8'h20, 1'b0);
            chk(!DIN_READY, "full_hold_ready", 32'(DIN_READY), 0);
        end
        out_log.delete();
        cyc(1'b1, 8'h20, 1'b1);
        chk(DIN_READY, "release_accept", 32'(DIN_READY), 1);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);
        chk(out_log.size() == 3, "bp_count", 32'(out_log.size()), 3);
        if (out_log.size() == 3) begin
            chk(out_log[0] == 24'h000100, "bp_out0", out_log[0], 24'h000100);
            chk(out_log[1] == 24'h000200, "bp_out1", out_log[1], 24'h000200);
            chk(out_log[2] == 24'h000400, "bp_out2", out_log[2], 24'h000400);
        end

        do_reset();
        n0 = out_cnt;
        cycles = 0;
        while (out_cnt - n0 < 10000 && cycles < 60000) begin
            cyc($urandom % 4 != 0, 8'($urandom), $urandom % 3 != 0);
            cycles++;
        end
        repeat (4) cyc(1'b0, 8'h00, 1'b1);
        chk(out_cnt - n0 >= 10000, "rand_count", 32'(out_cnt - n0), 10000);
        chk(sb.size() == 0, "rand_leftover", 32'(sb.size()), 0);

        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk(DOUT_VALID, "inflight_valid", 32'(DOUT_VALID), 1);
        #2;
        RSTN = 1'b0;
        DIN_VALID = 1'b0;
        #1;
        chk(!DOUT_VALID, "async_rst_valid", 32'(DOUT_VALID), 0);
        chk(DOUT == 24'h0, "async_rst_dout", DOUT, 0);
        sb.delete();
        stall = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        n0 = out_cnt;
        cyc(1'b0, 8'h00, 1'b1);
        chk(DIN_READY, "post_rst_ready", 32'(DIN_READY), 1);
        repeat (4) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk(!DOUT_VALID, "stale_out", 32'(DOUT_VALID), 0);
        end
        chk(out_cnt == n0, "stale_count", 32'(out_cnt - n0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
